// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the core's instruction
// fetch port (i_*) and its load/store data port (d_*). One non-pipelined
// transaction is in flight at a time. The fixed memory read latency is
// tracked, and each response is routed back to the port that issued it.
//
// Handshake: a requester raises *_req with stable request fields. The
// transaction is accepted in the cycle in which *_gnt=1, which is
// combinational on that cycle's requests. Dropping a request before its
// grant is legal. *_rvalid pulses for exactly one cycle, MEM_LATENCY cycles
// after the grant, and *_rdata is only meaningful while *_rvalid=1
// (otherwise it is 0).
//
// Parameters:
//   MEM_LATENCY  cycles from m_en to valid m_rdata (1..4)
//   MAX_STREAK   max consecutive data grants while fetch waits (1..15)
//
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   i_req/i_addr -> i_gnt              fetch request / accept
//   i_rvalid/i_rdata                   fetch response
//   d_req/d_we/d_be/d_addr/d_wdata     data request
//   d_gnt, d_rvalid/d_rdata            data accept / response (0 data on store ack)
//   m_en/m_we/m_be/m_addr/m_wdata      memory request strobe and fields
//   m_rdata                            memory read data
//   busy                               a transaction is outstanding
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_STREAK  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam logic [2:0] LAT        = 3'(MEM_LATENCY);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // All arbiter state lives in one struct so it can be observed as a unit.
  typedef struct packed {
    state_e     state;
    logic       owner;   // 0 = fetch, 1 = data
    logic       is_wr;   // outstanding transaction is a store
    logic [2:0] cnt;     // cycles until the response is valid
    logic [3:0] streak;  // consecutive data grants while fetch waited
  } arb_state_t;

  arb_state_t st_q, st_d;

  logic resp_cycle;
  logic grant_opp;
  logic grant_i;
  logic grant_d;
  logic rvalid_any;

  // Grant decision
  always_comb begin
    // The response cycle is also a grant opportunity, which gives one
    // transaction per MEM_LATENCY cycles when requests are back to back.
    resp_cycle = (st_q.state == ST_WAIT) && (st_q.cnt == 3'd1);
    grant_opp  = reset_n && ((st_q.state == ST_IDLE) || resp_cycle);
    // Data wins a tie, except when fetch has already lost MAX_STREAK times.
    grant_d    = grant_opp && d_req && !(i_req && (st_q.streak == STREAK_MAX));
    grant_i    = grant_opp && i_req && !grant_d;
    rvalid_any = reset_n && resp_cycle;
  end

  // Next state
  always_comb begin
    st_d = st_q;
    if (grant_i || grant_d) begin
      st_d.state = ST_WAIT;
      st_d.cnt   = LAT;
      st_d.owner = grant_d;
      st_d.is_wr = grant_d && d_we;
    end else if (st_q.state == ST_WAIT) begin
      if (st_q.cnt <= 3'd1) begin
        st_d.state = ST_IDLE;
        st_d.cnt   = 3'd0;
      end else begin
        st_d.cnt = st_q.cnt - 3'd1;
      end
    end

    // The streak only counts data wins while fetch is actually waiting.
    if (!i_req || grant_i) begin
      st_d.streak = 4'd0;
    end else if (grant_d && (st_q.streak != STREAK_MAX)) begin
      st_d.streak = st_q.streak + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q.state  <= ST_IDLE;
      st_q.owner  <= 1'b0;
      st_q.is_wr  <= 1'b0;
      st_q.cnt    <= 3'd0;
      st_q.streak <= 4'd0;
    end else begin
      st_q <= st_d;
    end
  end

  // Memory request: driven from the winner, all zero when there is no grant.
  always_comb begin
    m_en    = grant_i || grant_d;
    m_we    = 1'b0;
    m_be    = 4'h0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if (grant_d) begin
      m_we    = d_we;
      m_be    = d_we ? d_be : 4'hF;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (grant_i) begin
      m_be   = 4'hF;
      m_addr = i_addr;
    end
  end

  // Responses and status. While reset_n=0 everything is held at 0, so an
  // abandoned transaction can never surface.
  always_comb begin
    i_gnt    = grant_i;
    d_gnt    = grant_d;
    i_rvalid = rvalid_any && !st_q.owner;
    d_rvalid = rvalid_any && st_q.owner;
    i_rdata  = i_rvalid ? m_rdata : 32'h0;
    d_rdata  = (d_rvalid && !st_q.is_wr) ? m_rdata : 32'h0;
    busy     = reset_n && (st_q.state == ST_WAIT);
  end

endmodule
